// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// The FSM states, the funct3 access encodings and the wait-counter width live here.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the core and the data-memory responder.
interface dmem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic              req_re;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_funct3;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_re, req_addr, req_wdata, req_funct3,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_re, req_addr, req_wdata, req_funct3,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_mem_align.sv
// Byte-lane alignment for sub-word loads and stores: computes the byte enables, the merged
// store word, the extended load data and the misalignment/illegal-encoding flag.
module mem_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic              is_store,
  input  logic [DATA_W-1:0] rword,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wword,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] wrep;
  logic [7:0]        lbyte;
  logic [15:0]       lhalf;

  assign shifted = rword >> {lane, 3'b000};
  assign lbyte   = shifted[7:0];
  assign lhalf   = shifted[15:0];

  always_comb begin
    be   = '0;
    err  = 1'b0;
    wrep = wdata;
    case (funct3)
      F3_B, F3_BU: begin
        be   = 4'b0001 << lane;
        wrep = {4{wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        be   = 4'b0011 << lane;
        err  = lane[0];
        wrep = {2{wdata[15:0]}};
      end
      F3_W: begin
        be  = 4'b1111;
        err = (lane != 2'b00);
      end
      default: err = 1'b1;
    endcase
    // Unsigned encodings exist only for loads.
    if (is_store && (funct3 == F3_BU || funct3 == F3_HU)) begin
      err = 1'b1;
    end
    if (err) begin
      be = '0;
    end
  end

  always_comb begin
    wword = rword;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) begin
        wword[8*i +: 8] = wrep[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (!err && !is_store) begin
      case (funct3)
        F3_B:    rdata = {{24{lbyte[7]}}, lbyte};
        F3_BU:   rdata = {24'h0, lbyte};
        F3_H:    rdata = {{16{lhalf[15]}}, lhalf};
        F3_HU:   rdata = {16'h0, lhalf};
        F3_W:    rdata = rword;
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, performs the access and
// returns a one-cycle response. Memory contents are not reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  state_t              state;
  logic [WAIT_W-1:0]   cnt;
  logic                we_q;
  logic                re_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          f3_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_err_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-3:0]   word_idx;
  logic [DATA_W-1:0]   rword;
  logic [3:0]          be;
  logic [DATA_W-1:0]   wword;
  logic [DATA_W-1:0]   load_data;
  logic                align_err;
  logic                access;
  logic                acc_err;
  logic                do_write;

  assign word_idx = addr_q[ADDR_W-1:2];
  assign rword    = mem[word_idx];
  assign access   = (state == WAIT) && (cnt == '0);
  assign acc_err  = (we_q && re_q) || ((we_q || re_q) && align_err);
  // be is already cleared on any alignment/encoding error.
  assign do_write = access && we_q && !re_q && (|be);

  mem_align #(
    .DATA_W(DATA_W)
  ) u_align (
    .funct3  (f3_q),
    .lane    (addr_q[1:0]),
    .is_store(we_q),
    .rword   (rword),
    .wdata   (wdata_q),
    .be      (be),
    .wword   (wword),
    .rdata   (load_data),
    .err     (align_err)
  );

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[word_idx] <= wword;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      f3_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            re_q    <= bus.req_re;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            f3_q    <= bus.req_funct3;
            cnt     <= WAIT_W'(WAIT_CYCLES - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - WAIT_W'(1);
          end else begin
            state       <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= (re_q && !acc_err) ? load_data : '0;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && reset;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (W=2 and W=1), a per-instance behavioural model
// checked every cycle, and directed transactions with literal expectations.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        drv_valid [2];
  logic        drv_we    [2];
  logic        drv_re    [2];
  logic [10:0] drv_addr  [2];
  logic [31:0] drv_wdata [2];
  logic [2:0]  drv_f3    [2];

  logic        obs_ready [2];
  logic        obs_valid [2];
  logic        obs_err   [2];
  logic [31:0] obs_rdata [2];

  function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Reference semantics of one access: returns load data, error, and the updated word.
  function automatic void model_access(input logic we, input logic re, input logic [10:0] a,
                                       input logic [31:0] wd, input logic [2:0] f3,
                                       input logic [31:0] cur, output logic [31:0] rd,
                                       output logic e, output logic wr, output logic [31:0] nw);
    int lane, sz;
    logic [31:0] v;
    lane = int'(a[1:0]);
    rd = '0; e = 1'b0; wr = 1'b0; nw = cur;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (!we && !re) return;
    if (we && re) begin e = 1'b1; return; end
    if (sz == 0 || (we && f3[2])) begin e = 1'b1; return; end
    if ((lane % sz) != 0) begin e = 1'b1; return; end
    v = cur >> (8 * lane);
    if (we) begin
      wr = 1'b1;
      for (int i = 0; i < sz; i++) nw[8*(lane+i) +: 8] = wd[8*i +: 8];
    end else if (sz == 4) rd = cur;
    else if (sz == 2) rd = f3[2] ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    else rd = f3[2] ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int W = (g == 0) ? 2 : 1;

    dmem_responder_if #(.DATA_W(32), .ADDR_W(11)) bus ();

    dmem_responder #(.DATA_W(32), .ADDR_W(11), .WAIT_CYCLES(W)) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
    );

    assign bus.req_valid  = drv_valid[g];
    assign bus.req_we     = drv_we[g];
    assign bus.req_re     = drv_re[g];
    assign bus.req_addr   = drv_addr[g];
    assign bus.req_wdata  = drv_wdata[g];
    assign bus.req_funct3 = drv_f3[g];
    assign obs_ready[g]   = bus.req_ready;
    assign obs_valid[g]   = bus.rsp_valid;
    assign obs_err[g]     = bus.rsp_err;
    assign obs_rdata[g]   = bus.rsp_rdata;

    logic [31:0] mm [int];
    logic        busy = 1'b0;
    int          ecnt = 0;
    int          resp_edge = 0;
    int          done_edge = 0;
    logic        p_we, p_re;
    logic [10:0] p_addr;
    logic [31:0] p_wd;
    logic [2:0]  p_f3;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic [31:0] m_rdata = '0;

    always @(posedge clk) begin
      logic [31:0] cur, rd, nw;
      logic e, wr;
      int idx;
      ecnt++;
      m_valid = 1'b0;
      if (!rst_n) begin
        busy = 1'b0; m_err = 1'b0; m_rdata = '0;
      end else if (busy) begin
        if (ecnt == resp_edge) begin
          idx = int'(p_addr[10:2]);
          cur = mm.exists(idx) ? mm[idx] : 'x;
          model_access(p_we, p_re, p_addr, p_wd, p_f3, cur, rd, e, wr, nw);
          if (wr) mm[idx] = nw;
          m_valid = 1'b1; m_rdata = rd; m_err = e;
        end else if (ecnt == done_edge) begin
          busy = 1'b0;
        end
      end else if (drv_valid[g]) begin
        busy = 1'b1;
        resp_edge = ecnt + W;
        done_edge = ecnt + W + 1;
        p_we = drv_we[g]; p_re = drv_re[g]; p_addr = drv_addr[g];
        p_wd = drv_wdata[g]; p_f3 = drv_f3[g];
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        check32($sformatf("u%0d reset ready", g), 32'(bus.req_ready), 32'd0);
        check32($sformatf("u%0d reset rsp_valid", g), 32'(bus.rsp_valid), 32'd0);
        check32($sformatf("u%0d reset rdata", g), bus.rsp_rdata, 32'd0);
        check32($sformatf("u%0d reset err", g), 32'(bus.rsp_err), 32'd0);
      end else begin
        check32($sformatf("u%0d ready c%0d", g, ecnt), 32'(bus.req_ready), 32'(!busy));
        check32($sformatf("u%0d rsp_valid c%0d", g, ecnt), 32'(bus.rsp_valid), 32'(m_valid));
        check32($sformatf("u%0d rdata c%0d", g, ecnt), bus.rsp_rdata, m_rdata);
        check32($sformatf("u%0d err c%0d", g, ecnt), 32'(bus.rsp_err), 32'(m_err));
      end
    end
  end

  task automatic drive(input int i, input logic we, input logic re, input logic [10:0] a,
                       input logic [31:0] wd, input logic [2:0] f3);
    drv_we[i] = we; drv_re[i] = re; drv_addr[i] = a; drv_wdata[i] = wd; drv_f3[i] = f3;
    drv_valid[i] = 1'b1;
  endtask

  task automatic do_txn(input int i, input logic we, input logic re, input logic [10:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        input logic [31:0] exp_rd, input logic exp_err, input string name);
    int lat;
    bit seen;
    drive(i, we, re, a, wd, f3);
    @(posedge clk);
    #1;
    drv_valid[i] = 1'b0;
    // Scramble request fields after accept; they must not matter.
    drv_wdata[i] = ~wd;
    drv_addr[i]  = a ^ 11'h004;
    drv_we[i]    = ~we;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (obs_valid[i]) seen = 1'b1;
    end
    check32({name, " latency"}, 32'(lat), (i == 0) ? 32'd3 : 32'd2);
    check32({name, " rdata"}, obs_rdata[i], exp_rd);
    check32({name, " err"}, 32'(obs_err[i]), 32'(exp_err));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses, readies;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0; drv_we[i] = 1'b0; drv_re[i] = 1'b0;
      drv_addr[i] = '0; drv_wdata[i] = '0; drv_f3[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check32("por ready", 32'(obs_ready[0]), 32'd0);
    check32("por rsp_valid", 32'(obs_valid[0]), 32'd0);
    rst_n = 1'b1;

    // Reset in the middle of a store's wait drops it.
    do_txn(0, 1, 0, 11'h010, 32'h1234_5678, F3_W, 32'h0, 0, "sw 0x10");
    drive(0, 1, 0, 11'h010, 32'hDEAD_BEEF, F3_W);
    @(posedge clk);
    #1;
    drv_valid[0] = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check32("rst rsp_valid", 32'(obs_valid[0]), 32'd0);
      check32("rst ready", 32'(obs_ready[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_txn(0, 0, 1, 11'h010, 32'h0, F3_W, 32'h1234_5678, 0, "lw after rst");

    // Sub-word loads with sign/zero extension.
    do_txn(0, 1, 0, 11'h020, 32'h8081_F2F3, F3_W, 32'h0, 0, "sw 0x20");
    do_txn(0, 0, 1, 11'h021, 32'h0, F3_B,  32'hFFFF_FFF2, 0, "lb 0x21");
    do_txn(0, 0, 1, 11'h021, 32'h0, F3_BU, 32'h0000_00F2, 0, "lbu 0x21");
    do_txn(0, 0, 1, 11'h022, 32'h0, F3_H,  32'hFFFF_8081, 0, "lh 0x22");
    do_txn(0, 0, 1, 11'h022, 32'h0, F3_HU, 32'h0000_8081, 0, "lhu 0x22");

    // Byte/halfword store merging.
    do_txn(0, 1, 0, 11'h030, 32'h1122_3344, F3_W, 32'h0, 0, "sw 0x30");
    do_txn(0, 1, 0, 11'h031, 32'h0000_00AA, F3_B, 32'h0, 0, "sb 0x31");
    do_txn(0, 1, 0, 11'h032, 32'h0000_BEEF, F3_H, 32'h0, 0, "sh 0x32");
    do_txn(0, 0, 1, 11'h030, 32'h0, F3_W, 32'hBEEF_AA44, 0, "lw 0x30");

    // Errors leave memory untouched.
    do_txn(0, 1, 0, 11'h040, 32'hCAFE_0001, F3_W, 32'h0, 0, "sw 0x40");
    do_txn(0, 0, 1, 11'h042, 32'h0, F3_W, 32'h0, 1, "lw mis 0x42");
    do_txn(0, 1, 0, 11'h043, 32'h0000_1111, F3_H, 32'h0, 1, "sh mis 0x43");
    do_txn(0, 0, 1, 11'h040, 32'h0, 3'b011, 32'h0, 1, "ld f3 011");
    do_txn(0, 1, 1, 11'h040, 32'h5555_5555, F3_W, 32'h0, 1, "we&re");
    do_txn(0, 1, 0, 11'h040, 32'h0000_0077, F3_BU, 32'h0, 1, "st f3 100");
    do_txn(0, 0, 0, 11'h040, 32'h0, F3_W, 32'h0, 0, "no access");
    do_txn(0, 0, 1, 11'h040, 32'h0, F3_W, 32'hCAFE_0001, 0, "lw 0x40 kept");

    // Continuous requests on the W=1 instance: one accept every 3 cycles.
    do_txn(1, 1, 0, 11'h050, 32'h0BAD_F00D, F3_W, 32'h0, 0, "u1 sw 0x50");
    do_txn(1, 0, 1, 11'h050, 32'h0, F3_W, 32'h0BAD_F00D, 0, "u1 lw 0x50");
    drive(1, 0, 1, 11'h050, 32'h0, F3_W);
    pulses = 0;
    readies = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (obs_ready[1]) readies++;
      if (obs_valid[1]) begin
        pulses++;
        check32("stream rdata", obs_rdata[1], 32'h0BAD_F00D);
      end
    end
    drv_valid[1] = 1'b0;
    check32("stream pulses", 32'(pulses), 32'd4);
    check32("stream readies", 32'(readies), 32'd4);
    repeat (4) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
